// File: rtl/reduc_arbiter.sv
// Two-requester round-robin front end for a fixed-latency 49-bit modular reducer.
// Issue credits cover FIFO occupancy plus in-flight operations, so result FIFOs never overflow.

module reduc_arbiter_lane #(
  parameter int FDEPTH = 8,
  parameter int AW     = 3,
  parameter int DW     = 57
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic          retire,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          credit_ok
);
  localparam logic [AW+1:0] DEPTH_U = FDEPTH[AW+1:0];

  logic [DW-1:0] mem_q [FDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d, inflight_q, inflight_d;
  logic [AW+1:0] used;
  logic          pop;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // Head is masked while empty so outputs read zero out of reset without clearing the array.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign used      = {1'b0, count_q} + {1'b0, inflight_q};
  assign credit_ok = (used < DEPTH_U);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    case ({issue, retire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

module reduc_arbiter #(
  parameter int LAT    = 5,
  parameter int FDEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [73:0] req0_data,
  input  logic        req0_shift,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [73:0] req1_data,
  input  logic        req1_shift,
  output logic        out0_valid,
  input  logic        out0_ready,
  output logic [48:0] out0_full,
  output logic [7:0]  out0_byte,
  output logic        out1_valid,
  input  logic        out1_ready,
  output logic [48:0] out1_full,
  output logic [7:0]  out1_byte,
  output logic [73:0] red_din,
  output logic        red_din_flag,
  output logic        red_shift_mod,
  input  logic [48:0] red_dout_full,
  input  logic [7:0]  red_dout,
  input  logic        red_dout_flag,
  input  logic        flush,
  output logic        flush_done,
  output logic        err
);
  localparam int AW = $clog2(FDEPTH);
  localparam int WW = $clog2(LAT + 1);
  localparam logic [WW-1:0] WARM_MAX = LAT[WW-1:0];

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [LAT:1]   vld_pipe_q, vld_pipe_d, id_pipe_q, id_pipe_d, sh_pipe_q, sh_pipe_d;
  logic           last_q, last_d, err_q, err_d;
  logic [WW-1:0]  warm_q, warm_d;
  logic [1:0]     req_valid, req_shift, credit_ok, elig, gnt;
  logic [1:0]     lane_push, lane_retire, out_valid_v, out_ready_v;
  logic [1:0][73:0] req_data;
  logic [1:0][56:0] out_data;
  logic           issue, issue_id, retire, retire_id, pipe_busy, warm_ok, write;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_shift   = {req1_shift, req0_shift};
  assign req_data    = {req1_data, req0_data};
  assign out_ready_v = {out1_ready, out0_ready};

  assign retire    = vld_pipe_q[LAT];
  assign retire_id = id_pipe_q[LAT];
  assign warm_ok   = (warm_q == WARM_MAX);
  assign write     = retire && red_dout_flag;

  always_comb begin
    elig = (state_q == RUN) ? (req_valid & credit_ok) : 2'b00;
    gnt  = elig;
    if (&elig) gnt = last_q ? 2'b01 : 2'b10;
    issue    = |gnt;
    issue_id = gnt[1];
    last_d   = issue ? issue_id : last_q;

    vld_pipe_d    = vld_pipe_q;
    id_pipe_d     = id_pipe_q;
    sh_pipe_d     = sh_pipe_q;
    vld_pipe_d[1] = issue;
    id_pipe_d[1]  = issue_id;
    sh_pipe_d[1]  = issue_id ? req_shift[1] : req_shift[0];
    for (int i = 2; i <= LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      id_pipe_d[i]  = id_pipe_q[i-1];
      sh_pipe_d[i]  = sh_pipe_q[i-1];
    end

    // Stage LAT retires this cycle, so only the earlier stages keep a drain alive.
    pipe_busy = 1'b0;
    for (int i = 1; i < LAT; i++) pipe_busy = pipe_busy | vld_pipe_q[i];

    lane_retire = retire ? (retire_id ? 2'b10 : 2'b01) : 2'b00;
    lane_push   = write  ? (retire_id ? 2'b10 : 2'b01) : 2'b00;

    // Stale reducer strobes from before reset are ignored until the warm-up count expires.
    warm_d = warm_ok ? warm_q : warm_q + 1'b1;
    err_d  = err_q | (warm_ok && (retire != red_dout_flag));

    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      IDLE:  if (!flush) state_d = RUN;
      RUN:   if (flush) state_d = DRAIN;
      DRAIN: if (!pipe_busy) begin
        state_d    = IDLE;
        flush_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      sh_pipe_q  <= '0;
      last_q     <= 1'b1;
      err_q      <= 1'b0;
      warm_q     <= '0;
    end else begin
      state_q    <= state_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
      sh_pipe_q  <= sh_pipe_d;
      last_q     <= last_d;
      err_q      <= err_d;
      warm_q     <= warm_d;
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_lane
    reduc_arbiter_lane #(.FDEPTH(FDEPTH), .AW(AW), .DW(57)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .issue     (gnt[n]),
      .retire    (lane_retire[n]),
      .push      (lane_push[n]),
      .push_data ({red_dout_full, red_dout}),
      .out_ready (out_ready_v[n]),
      .out_valid (out_valid_v[n]),
      .out_data  (out_data[n]),
      .credit_ok (credit_ok[n])
    );
  end

  assign req0_ready    = gnt[0];
  assign req1_ready    = gnt[1];
  assign red_din_flag  = issue;
  assign red_din       = issue ? req_data[issue_id] : '0;
  assign red_shift_mod = sh_pipe_q[LAT];
  assign out0_valid    = out_valid_v[0];
  assign out1_valid    = out_valid_v[1];
  assign out0_full     = out_data[0][56:8];
  assign out0_byte     = out_data[0][7:0];
  assign out1_full     = out_data[1][56:8];
  assign out1_byte     = out_data[1][7:0];
  assign err           = err_q;
endmodule
